// File: rtl/spring_scheduler.sv
// spring_scheduler: walks NUM_NODES body nodes per frame, collects spring forces
// and emits the saturated axle reaction. Optional WAIT watchdog: SPRING_SCHED_TIMEOUT_EN.
module spring_scheduler #(
  parameter int NUM_NODES  = 10,
  parameter int FORCE_SIZE = 8,
  parameter int ACC_SIZE   = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 frame_tick_in,
  input  logic                                 clr_flags_in,
  output logic                                 req_out,
  output logic [$clog2(NUM_NODES)-1:0]         node_idx_out,
  input  logic                                 force_valid_in,
  input  logic signed [FORCE_SIZE-1:0]         force_x_in,
  input  logic signed [FORCE_SIZE-1:0]         force_y_in,
  output logic signed [FORCE_SIZE-1:0]         node_force_x_out,
  output logic signed [FORCE_SIZE-1:0]         node_force_y_out,
  output logic                                 node_force_valid_out,
  output logic signed [FORCE_SIZE-1:0]         axle_force_x_out,
  output logic signed [FORCE_SIZE-1:0]         axle_force_y_out,
  output logic                                 frame_done_out,
  output logic                                 busy_out,
  output logic                                 overrun_out,
  output logic                                 timeout_out
);

  localparam int IDX_W = $clog2(NUM_NODES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NODES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ACC_SIZE-1:0]   acc_x_q, acc_x_d;
  logic [ACC_SIZE-1:0]   acc_y_q, acc_y_d;
  logic [FORCE_SIZE-1:0] nfx_q, nfx_d;
  logic [FORCE_SIZE-1:0] nfy_q, nfy_d;
  logic                  nfv_q, nfv_d;
  logic [FORCE_SIZE-1:0] axle_x_q, axle_x_d;
  logic [FORCE_SIZE-1:0] axle_y_q, axle_y_d;
  logic                  done_q, done_d;
  logic                  req_q, req_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic                  tmo_fire;
  logic                  advance;

  function automatic logic [ACC_SIZE-1:0] sext(
    input logic [FORCE_SIZE-1:0] f
  );
    sext = {{(ACC_SIZE-FORCE_SIZE){f[FORCE_SIZE-1]}}, f};
  endfunction

  // Reaction force is the negated sum; one extra bit keeps -min exact.
  function automatic logic [FORCE_SIZE-1:0] neg_sat(
    input logic [ACC_SIZE-1:0] a
  );
    logic [ACC_SIZE:0]                n;
    logic [ACC_SIZE-FORCE_SIZE+1:0]   top;
    n   = ~{a[ACC_SIZE-1], a} + (ACC_SIZE+1)'(1);
    top = n[ACC_SIZE:FORCE_SIZE-1];
    if ((&top) || !(|top))
      neg_sat = n[FORCE_SIZE-1:0];
    else if (n[ACC_SIZE])
      neg_sat = {1'b1, {(FORCE_SIZE-1){1'b0}}};
    else
      neg_sat = {1'b0, {(FORCE_SIZE-1){1'b1}}};
  endfunction

`ifdef SPRING_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;

  // Watchdog counts unanswered WAIT cycles; restarts on every new WAIT.
  always_comb begin
    tmo_fire  = (state_q == S_WAIT) && !force_valid_in &&
                (tmo_cnt_q == TW'(TIMEOUT - 1));
    tmo_cnt_d = '0;
    if ((state_q == S_WAIT) && !force_valid_in && !tmo_fire)
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    timeout_d = (timeout_q & ~clr_flags_in) | tmo_fire;
  end

  // Watchdog state registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_out = timeout_q;
`else
  assign tmo_fire    = 1'b0;
  assign timeout_out = 1'b0;
`endif

  // Frame sequencer, accumulation and registered output selection.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    nfx_d    = nfx_q;
    nfy_d    = nfy_q;
    nfv_d    = 1'b0;
    axle_x_d = axle_x_q;
    axle_y_d = axle_y_q;
    done_d   = 1'b0;
    advance  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_tick_in) begin
          state_d = S_ISSUE;
          idx_d   = '0;
          acc_x_d = '0;
          acc_y_d = '0;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (force_valid_in) begin
          nfx_d   = force_x_in;
          nfy_d   = force_y_in;
          nfv_d   = 1'b1;
          acc_x_d = acc_x_q + sext(force_x_in);
          acc_y_d = acc_y_q + sext(force_y_in);
          advance = 1'b1;
        end else if (tmo_fire) begin
          advance = 1'b1;
        end
        if (advance) begin
          if (idx_q < LAST) begin
            state_d = S_ISSUE;
            idx_d   = idx_q + IDX_W'(1);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Axle result and done pulse are presented during the DONE cycle.
    if (state_d == S_DONE) begin
      axle_x_d = neg_sat(acc_x_d);
      axle_y_d = neg_sat(acc_y_d);
      done_d   = 1'b1;
    end
    req_d     = (state_d == S_ISSUE);
    busy_d    = (state_d != S_IDLE);
    overrun_d = (overrun_q & ~clr_flags_in) | (frame_tick_in & busy_q);
  end

  // State and output registers; reset drops any partial frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      acc_x_q   <= '0;
      acc_y_q   <= '0;
      nfx_q     <= '0;
      nfy_q     <= '0;
      nfv_q     <= 1'b0;
      axle_x_q  <= '0;
      axle_y_q  <= '0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_x_q   <= acc_x_d;
      acc_y_q   <= acc_y_d;
      nfx_q     <= nfx_d;
      nfy_q     <= nfy_d;
      nfv_q     <= nfv_d;
      axle_x_q  <= axle_x_d;
      axle_y_q  <= axle_y_d;
      done_q    <= done_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign req_out              = req_q;
  assign node_idx_out         = idx_q;
  assign node_force_x_out     = nfx_q;
  assign node_force_y_out     = nfy_q;
  assign node_force_valid_out = nfv_q;
  assign axle_force_x_out     = axle_x_q;
  assign axle_force_y_out     = axle_y_q;
  assign frame_done_out       = done_q;
  assign busy_out             = busy_q;
  assign overrun_out          = overrun_q;

endmodule

// File: tb/tb_spring_scheduler.sv
// tb_spring_scheduler: directed and random frames against a sum-and-saturate model.
// Timeout scenario runs only when SPRING_SCHED_TIMEOUT_EN is defined.
module tb_spring_scheduler;

  localparam int N  = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic clr = 1'b0;
  logic fv = 1'b0;
  logic signed [7:0] fx = '0;
  logic signed [7:0] fy = '0;
  logic req, nfv, done, busy, ovr, tmo;
  logic [1:0] idx;
  logic signed [7:0] nfx, nfy, ax, ay;

  spring_scheduler #(
    .NUM_NODES(N), .FORCE_SIZE(8), .ACC_SIZE(16), .TIMEOUT(TO)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .frame_tick_in(tick), .clr_flags_in(clr),
    .req_out(req), .node_idx_out(idx),
    .force_valid_in(fv), .force_x_in(fx), .force_y_in(fy),
    .node_force_x_out(nfx), .node_force_y_out(nfy),
    .node_force_valid_out(nfv),
    .axle_force_x_out(ax), .axle_force_y_out(ay),
    .frame_done_out(done), .busy_out(busy),
    .overrun_out(ovr), .timeout_out(tmo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int nfv_cnt = 0;
  int done_cnt = 0;
  int xs[N];
  int ys[N];

  always @(negedge clk) begin
    if (nfv === 1'b1) nfv_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int model_axle(input int v[N], input int skip);
    int s = 0;
    for (int i = 0; i < N; i++)
      if (i != skip) s += v[i];
    return sat8(-s);
  endfunction

  task automatic wait_req(input int n);
    int c = 0;
    while (req !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("req_seen", req, 1);
    chk("node_idx", idx, n);
  endtask

  // mode 1: extra tick mid-frame; mode 2: extra tick plus clear together
  task automatic respond(input int n, input int l, input int mode);
    wait_req(n);
    for (int k = 0; k < l; k++) begin
      @(negedge clk);
      tick = (k == 0) && (mode != 0);
      clr  = (k == 0) && (mode == 2);
    end
    tick = 1'b0;
    clr  = 1'b0;
    fv = 1'b1;
    fx = 8'(xs[n]);
    fy = 8'(ys[n]);
    @(negedge clk);
    fv = 1'b0;
    chk("nfv_pulse", nfv, 1);
    chk("node_fx", nfx, xs[n]);
    chk("node_fy", nfy, ys[n]);
  endtask

`ifdef SPRING_SCHED_TIMEOUT_EN
  task automatic respond_skip(input int n);
    int c = 0;
    wait_req(n);
    @(negedge clk);
    c = 1;
    while (req !== 1'b1 && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("tmo_gap", c, TO + 1);
    chk("tmo_next_idx", idx, n + 1);
    chk("tmo_flag", tmo, 1);
  endtask
`endif

  task automatic finish_frame(input int ex, input int ey);
    int c = 0;
    while (done !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("frame_done", done, 1);
    chk("axle_x", ax, ex);
    chk("axle_y", ay, ey);
    chk("busy_in_done", busy, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic run_frame(input int l, input int skip, input int mode);
    int d0, v0, nexp;
    d0 = done_cnt;
    v0 = nfv_cnt;
    nexp = N;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int n = 0; n < N; n++) begin
`ifdef SPRING_SCHED_TIMEOUT_EN
      if (n == skip) begin
        respond_skip(n);
        nexp--;
      end else
`endif
      respond(n, l, (n == 1) ? mode : 0);
    end
    finish_frame(model_axle(xs, skip), model_axle(ys, skip));
    #1;
    chk("done_count", done_cnt - d0, 1);
    chk("nfv_count", nfv_cnt - v0, nexp);
  endtask

  initial begin
    int d0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_idx", idx, 0);
    chk("rst_nfv", nfv, 0);
    chk("rst_ax", ax, 0);
    chk("rst_ay", ay, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_tmo", tmo, 0);
    rst = 1'b0;

    xs = '{10, 20, 30, 40};
    ys = '{-5, -5, -5, -5};
    run_frame(2, -1, 0);
    chk("basic_ax", ax, -100);
    chk("basic_ay", ay, 20);
    chk("no_overrun", ovr, 0);

    @(negedge clk);
    fv = 1'b1;
    fx = 8'sd50;
    fy = 8'sd50;
    @(negedge clk);
    fv = 1'b0;
    chk("idle_fv_nfv", nfv, 0);
    chk("idle_fv_nfx", nfx, 40);
    chk("idle_fv_ax", ax, -100);
    chk("idle_fv_busy", busy, 0);

    xs = '{127, 127, 127, 127};
    ys = '{-128, -128, -128, -128};
    run_frame(1, -1, 0);
    chk("sat_ax", ax, -128);
    chk("sat_ay", ay, 127);

    xs = '{1, 2, 3, 4};
    ys = '{-1, -2, -3, -4};
    run_frame(2, -1, 1);
    chk("overrun_set", ovr, 1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("overrun_clr", ovr, 0);
    run_frame(3, -1, 2);
    chk("set_wins", ovr, 1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("overrun_clr2", ovr, 0);

    xs = '{5, 6, 7, 8};
    ys = '{9, 9, 9, 9};
    d0 = done_cnt;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    respond(0, 2, 0);
    respond(1, 2, 0);
    wait_req(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_idx", idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ax", ax, 0);
    chk("mid_rst_ay", ay, 0);
    chk("mid_rst_nfx", nfx, 0);
    chk("mid_rst_nfv", nfv, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_rst_no_done", done_cnt - d0, 0);
    run_frame(2, -1, 0);

`ifdef SPRING_SCHED_TIMEOUT_EN
    xs = '{11, 99, 22, 33};
    ys = '{-7, 50, -8, -9};
    run_frame(2, 1, 0);
    chk("tmo_ax", ax, -66);
    chk("tmo_ay", ay, 24);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("tmo_clr", tmo, 0);
`else
    chk("tmo_tied", tmo, 0);
`endif

    repeat (8) begin
      for (int i = 0; i < N; i++) begin
        xs[i] = int'($urandom_range(0, 255)) - 128;
        ys[i] = int'($urandom_range(0, 255)) - 128;
      end
      run_frame(int'($urandom_range(1, 4)), -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
